// File: rtl/fifo_wrr_scheduler_pkg.sv
// Shared definitions for the weighted round-robin FIFO pop scheduler.
//   sched_state_e   : scheduler FSM states (IDLE, SERVE)
//   STATS_CNT_WIDTH : width of each per-queue served counter, which exists only
//                     when FIFO_WRR_SCHEDULER_STATS_EN is defined
package fifo_wrr_scheduler_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } sched_state_e;

  localparam int STATS_CNT_WIDTH = 16;

endpackage

// File: rtl/fifo_wrr_pick.sv
// Combinational round-robin search.
// It looks for the first requesting, non-excluded entry, starting at start and
// moving upward with wrap-around.
//   req     : request vector, one bit per queue
//   start   : index that is searched first
//   exclude : mask of entries to skip
//   found   : some entry qualified
//   idx     : index of the first qualifying entry (0 when none is found)
module fifo_wrr_pick #(
  parameter int NUM_QUEUES = 4,
  parameter int IDX_WIDTH  = $clog2(NUM_QUEUES)
) (
  input  logic [NUM_QUEUES-1:0] req,
  input  logic [IDX_WIDTH-1:0]  start,
  input  logic [NUM_QUEUES-1:0] exclude,
  output logic                  found,
  output logic [IDX_WIDTH-1:0]  idx
);

  logic [IDX_WIDTH:0]   sum;
  logic [IDX_WIDTH-1:0] pos;

  // The loop walks from the farthest offset down to offset 0.
  // The last hit therefore wins, and that hit is the one nearest to start.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    pos   = '0;
    for (int k = NUM_QUEUES - 1; k >= 0; k--) begin
      sum = {1'b0, start} + (IDX_WIDTH+1)'(k);
      if (sum >= (IDX_WIDTH+1)'(NUM_QUEUES)) sum = sum - (IDX_WIDTH+1)'(NUM_QUEUES);
      pos = sum[IDX_WIDTH-1:0];
      if (req[pos] && !exclude[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/fifo_wrr_scheduler.sv
// Weighted round-robin pop controller for a bank of FIFOs.
// One queue is granted at a time, for up to max(weight,1) consecutive pops.
// The granted head is presented on a single valid/ready stream.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clr_i          : synchronous clear; it overrides everything else
//   weight_i       : per-queue burst quantum, sampled at grant time (0 acts as 1)
//   fifo_empty_i   : empty flag of each FIFO
//   fifo_data_i    : head data of each FIFO
//   fifo_pop_o     : pop strobe of each FIFO, one-hot or zero
//   data_o/valid_o/ready_i : output stream
//   idx_o, busy_o  : index of the granted queue, and a flag that a grant is held
//   state_o        : current FSM state, for debug (1 = SERVE)
//   served_cnt_o   : saturating per-queue pop counters, present only when
//                    FIFO_WRR_SCHEDULER_STATS_EN is defined
// Handshake: a beat transfers when valid_o & ready_i are both high.
// valid_o never depends on ready_i.
// Once valid_o is raised, it stays high and data_o stays stable until the beat
// transfers. The only exceptions are clr_i and reset.
module fifo_wrr_scheduler
  import fifo_wrr_scheduler_pkg::*;
#(
  parameter int  NUM_QUEUES   = 4,
  parameter int  WEIGHT_WIDTH = 4,
  parameter int  DATA_WIDTH   = 32,
  parameter type dtype        = logic [DATA_WIDTH-1:0],
  parameter int  IDX_WIDTH    = $clog2(NUM_QUEUES)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    clr_i,
  input  logic [NUM_QUEUES-1:0][WEIGHT_WIDTH-1:0] weight_i,
  input  logic [NUM_QUEUES-1:0]                   fifo_empty_i,
  input  dtype                                    fifo_data_i [NUM_QUEUES],
  output logic [NUM_QUEUES-1:0]                   fifo_pop_o,
  output dtype                                    data_o,
  output logic                                    valid_o,
  input  logic                                    ready_i,
  output logic [IDX_WIDTH-1:0]                    idx_o,
  output logic                                    busy_o,
  output logic                                    state_o
`ifdef FIFO_WRR_SCHEDULER_STATS_EN
  ,
  output logic [NUM_QUEUES-1:0][STATS_CNT_WIDTH-1:0] served_cnt_o
`endif
);

  sched_state_e            state_q, state_d;
  logic [IDX_WIDTH-1:0]    grant_q, grant_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
  logic [IDX_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;

  logic                    serving, drained, transfer, release_grant;
  logic [IDX_WIDTH-1:0]    next_ptr, pick_start, pick_idx;
  logic [NUM_QUEUES-1:0]   pick_exclude;
  logic                    pick_found;
  logic [WEIGHT_WIDTH-1:0] pick_weight, quantum;

  assign serving  = (state_q == SERVE);
  // A granted queue that shows empty has run dry, so the grant is given back.
  assign drained  = serving & fifo_empty_i[grant_q];
  assign valid_o  = serving & ~fifo_empty_i[grant_q] & ~clr_i;
  assign transfer = valid_o & ready_i;
  assign next_ptr = (grant_q == IDX_WIDTH'(NUM_QUEUES - 1)) ? '0 : grant_q + IDX_WIDTH'(1);

  assign release_grant = (transfer && credit_q <= WEIGHT_WIDTH'(1)) || drained;

  assign data_o  = fifo_data_i[grant_q];
  assign idx_o   = serving ? grant_q : '0;
  assign busy_o  = serving;
  assign state_o = state_q;

  always_comb begin
    fifo_pop_o = '0;
    if (transfer) fifo_pop_o[grant_q] = 1'b1;
  end

  // In SERVE the search starts just past the grant, so the released queue is
  // looked at last. A queue that ran dry is masked out of the search.
  always_comb begin
    pick_exclude = '0;
    if (drained) pick_exclude[grant_q] = 1'b1;
  end
  assign pick_start = serving ? next_ptr : rr_ptr_q;

  fifo_wrr_pick #(
    .NUM_QUEUES (NUM_QUEUES),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_pick (
    .req     (~fifo_empty_i),
    .start   (pick_start),
    .exclude (pick_exclude),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  assign pick_weight = weight_i[pick_idx];
  assign quantum     = (pick_weight == '0) ? WEIGHT_WIDTH'(1) : pick_weight;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    credit_d = credit_q;
    rr_ptr_d = rr_ptr_q;
    if (clr_i) begin
      state_d  = IDLE;
      grant_d  = '0;
      credit_d = '0;
      rr_ptr_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_d  = SERVE;
            grant_d  = pick_idx;
            credit_d = quantum;
          end
        end
        SERVE: begin
          if (transfer && credit_q != '0) credit_d = credit_q - WEIGHT_WIDTH'(1);
          if (release_grant) begin
            rr_ptr_d = next_ptr;
            if (pick_found) begin
              grant_d  = pick_idx;
              credit_d = quantum;
            end else begin
              state_d  = IDLE;
              credit_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      credit_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      credit_q <= credit_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef FIFO_WRR_SCHEDULER_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      served_cnt_o <= '0;
    end else if (clr_i) begin
      served_cnt_o <= '0;
    end else begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        if (fifo_pop_o[q] && served_cnt_o[q] != '1)
          served_cnt_o[q] <= served_cnt_o[q] + STATS_CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wrr_scheduler.sv
// Bench for fifo_wrr_scheduler (4 queues, 4-bit weights, 32-bit data).
// The FIFOs are modelled as queues inside the bench.
// The expected pop order is derived from the weighted round-robin rules.
// Stats checks are compiled only when FIFO_WRR_SCHEDULER_STATS_EN is defined.
module tb_fifo_wrr_scheduler;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int W  = 2 + DW;

  logic              clk = 1'b0;
  logic              rst_n, clr;
  logic [N-1:0][3:0] weight;
  logic [N-1:0]      fifo_empty;
  logic [DW-1:0]     fifo_data [N];
  logic [N-1:0]      fifo_pop;
  logic [DW-1:0]     data;
  logic              valid, ready;
  logic [1:0]        idx;
  logic              busy, state;
`ifdef FIFO_WRR_SCHEDULER_STATS_EN
  logic [N-1:0][15:0] served_cnt;
`endif

  fifo_wrr_scheduler dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clr_i        (clr),
    .weight_i     (weight),
    .fifo_empty_i (fifo_empty),
    .fifo_data_i  (fifo_data),
    .fifo_pop_o   (fifo_pop),
    .data_o       (data),
    .valid_o      (valid),
    .ready_i      (ready),
    .idx_o        (idx),
    .busy_o       (busy),
    .state_o      (state)
`ifdef FIFO_WRR_SCHEDULER_STATS_EN
    ,
    .served_cnt_o (served_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fq [N][$];
  logic [W-1:0]  exp_q [$];
  int errors = 0;
  int checks = 0;

  logic          s_valid, s_ready, s_busy;
  logic [DW-1:0] s_data;
  logic [1:0]    s_idx;
  logic [N-1:0]  s_pop;

  task automatic update_inputs();
    for (int q = 0; q < N; q++) begin
      fifo_empty[q] = (fq[q].size() == 0);
      fifo_data[q]  = (fq[q].size() != 0) ? fq[q][0] : '0;
    end
  endtask

  // Reference order: start at pointer 0 and take the first non-empty queue
  // with wrap-around. Take min(max(w,1), len) entries from it. The pointer then
  // moves to the queue after it.
  task automatic build_expected();
    int len [N];
    int head [N];
    int ptr, sel, w, n;
    logic [1:0] qi;
    for (int q = 0; q < N; q++) begin
      len[q]  = fq[q].size();
      head[q] = 0;
    end
    ptr = 0;
    forever begin
      sel = -1;
      for (int k = N - 1; k >= 0; k--) if (len[(ptr + k) % N] > 0) sel = (ptr + k) % N;
      if (sel < 0) break;
      w  = (weight[sel] == 0) ? 1 : int'(weight[sel]);
      n  = (w < len[sel]) ? w : len[sel];
      qi = sel[1:0];
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({qi, fq[sel][head[sel]]});
        head[sel]++;
        len[sel]--;
      end
      ptr = (sel + 1) % N;
    end
  endtask

  // One clock: sample the outputs at negedge, score any transfer, then apply
  // the pops to the FIFO models just after posedge.
  task automatic cycle();
    logic [W-1:0] e;
    logic [N-1:0] oh;
    @(negedge clk);
    s_valid = valid; s_ready = ready; s_busy = busy;
    s_data = data; s_idx = idx; s_pop = fifo_pop;
    if (s_valid && s_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: transfer idx=%0d data=%h, required none", s_idx, s_data);
      end else begin
        e = exp_q.pop_front();
        if ({s_idx, s_data} !== e) begin
          errors++;
          $display("FAIL sb_order: got idx=%0d data=%h, required idx=%0d data=%h",
                   s_idx, s_data, e[W-1:DW], e[DW-1:0]);
        end
      end
      oh = 4'b0001 << s_idx;
      checks++;
      if (s_pop !== oh) begin
        errors++;
        $display("FAIL pop_onehot: got %b, required %b", s_pop, oh);
      end
    end else begin
      checks++;
      if (s_pop !== 4'b0000) begin
        errors++;
        $display("FAIL pop_no_transfer: got %b, required 0000", s_pop);
      end
    end
    @(posedge clk);
    #1;
    for (int q = 0; q < N; q++) if (s_pop[q] && fq[q].size() > 0) void'(fq[q].pop_front());
    update_inputs();
  endtask

  // Load the FIFO models and weights while clr_i is held, so the run starts
  // from IDLE with the pointer at 0.
  task automatic prep(input logic [N-1:0][3:0] w, input int d0, input int d1, input int d2, input int d3);
    int depth [N];
    depth[0] = d0; depth[1] = d1; depth[2] = d2; depth[3] = d3;
    clr = 1'b1;
    weight = w;
    for (int q = 0; q < N; q++) begin
      fq[q].delete();
      for (int i = 0; i < depth[q]; i++) fq[q].push_back($urandom);
    end
    update_inputs();
    cycle();
    clr = 1'b0;
    exp_q.delete();
    build_expected();
  endtask

  task automatic drain(input string name, input int max_cycles, input bit rand_ready);
    int cyc = 0;
    int pending;
    forever begin
      pending = exp_q.size();
      for (int q = 0; q < N; q++) pending += fq[q].size();
      if (pending == 0 || cyc >= max_cycles) break;
      ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      cycle();
      cyc++;
    end
    checks++;
    if (pending != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d items pending after %0d cycles, required 0", name, pending, cyc);
    end
    ready = 1'b1;
    repeat (3) cycle();
    checks++;
    if (s_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b after drain, required 0", name, s_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; ready = 1'b1; weight = '0;
    for (int q = 0; q < N; q++) fq[q].delete();
    fq[0].push_back(32'h1234_5678);
    update_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", valid); end
    checks++; if (fifo_pop !== 4'b0) begin errors++; $display("FAIL reset_pop: got %b, required 0000", fifo_pop); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d, required 0", idx); end
    checks++; if (state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b, required 0 (IDLE)", state); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    fq[0].delete();
    update_inputs();
  endtask

  task automatic test_single();
    prep({4'd5, 4'd3, 4'd2, 4'd1}, 0, 0, 0, 0);
    ready = 1'b1;
    cycle();
    for (int i = 0; i < 3; i++) fq[2].push_back($urandom);
    update_inputs();
    build_expected();
    cycle();
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL single_lat0: valid=%b, required 0", s_valid); end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (s_valid !== 1'b1 || s_idx !== 2'd2) begin
        errors++;
        $display("FAIL single_pop%0d: valid=%b idx=%0d, required valid=1 idx=2", i, s_valid, s_idx);
      end
    end
    drain("single", 50, 1'b0);
  endtask

  task automatic test_fairness();
    int order [8] = '{0, 1, 1, 2, 2, 2, 3, 0};
    prep({4'd0, 4'd3, 4'd2, 4'd1}, 6, 6, 6, 6);
    ready = 1'b1;
    cycle();
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL fair_idle: valid=%b, required 0", s_valid); end
    for (int i = 0; i < 8; i++) begin
      cycle();
      checks++;
      if (s_valid !== 1'b1 || int'(s_idx) != order[i]) begin
        errors++;
        $display("FAIL fair_beat%0d: valid=%b idx=%0d, required valid=1 idx=%0d", i, s_valid, s_idx, order[i]);
      end
    end
    drain("fair", 300, 1'b1);
  endtask

  task automatic test_early_empty();
    prep({4'd2, 4'd7, 4'd5, 4'd1}, 0, 2, 0, 2);
    ready = 1'b1;
    cycle();
    cycle();
    cycle();
    cycle();
    checks++;
    if (s_valid !== 1'b0 || s_busy !== 1'b1) begin
      errors++;
      $display("FAIL early_release: valid=%b busy=%b, required valid=0 busy=1", s_valid, s_busy);
    end
    cycle();
    checks++;
    if (s_valid !== 1'b1 || s_idx !== 2'd3) begin
      errors++;
      $display("FAIL early_regrant: valid=%b idx=%0d, required valid=1 idx=3", s_valid, s_idx);
    end
    drain("early", 50, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d0;
    prep({4'd1, 4'd1, 4'd1, 4'd3}, 4, 2, 0, 0);
    ready = 1'b0;
    cycle();
    cycle();
    d0 = fq[0][0];
    checks++;
    if (s_valid !== 1'b1 || s_idx !== 2'd0 || s_data !== d0) begin
      errors++;
      $display("FAIL bp_first: valid=%b idx=%0d data=%h, required 1/0/%h", s_valid, s_idx, s_data, d0);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (s_valid !== 1'b1 || s_pop !== 4'b0 || s_idx !== 2'd0 || s_data !== d0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b pop=%b idx=%0d data=%h, required 1/0000/0/%h",
                 i, s_valid, s_pop, s_idx, s_data, d0);
      end
    end
    drain("bp", 50, 1'b0);
  endtask

  task automatic test_clr_mid();
    prep({4'd1, 4'd1, 4'd4, 4'd1}, 0, 5, 0, 0);
    ready = 1'b1;
    cycle();
    cycle();
    cycle();
    clr = 1'b1;
    cycle();
    checks++;
    if (s_valid !== 1'b0 || s_pop !== 4'b0) begin
      errors++;
      $display("FAIL clr_same_cycle: valid=%b pop=%b, required 0/0000", s_valid, s_pop);
    end
    clr = 1'b0;
    exp_q.delete();
    fq[0].push_back($urandom);
    fq[0].push_back($urandom);
    update_inputs();
    build_expected();
    cycle();
    checks++;
    if (s_busy !== 1'b0 || s_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_idle: busy=%b valid=%b, required 0/0", s_busy, s_valid);
    end
    cycle();
    checks++;
    if (s_valid !== 1'b1 || s_idx !== 2'd0) begin
      errors++;
      $display("FAIL clr_first_q0: valid=%b idx=%0d, required 1/0", s_valid, s_idx);
    end
    drain("clr", 60, 1'b1);
  endtask

  task automatic test_random();
    logic [N-1:0][3:0] w;
    for (int r = 0; r < 8; r++) begin
      for (int q = 0; q < N; q++) w[q] = 4'($urandom_range(0, 15));
      prep(w, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      drain("rand", 600, 1'b1);
    end
  endtask

`ifdef FIFO_WRR_SCHEDULER_STATS_EN
  task automatic test_stats();
    prep({4'd1, 4'd1, 4'd1, 4'd0}, 70000, 0, 0, 0);
    drain("stats", 71000, 1'b0);
    checks++;
    if (served_cnt[0] !== 16'hFFFF || served_cnt[1] !== 16'h0) begin
      errors++;
      $display("FAIL stats_sat: cnt0=%h cnt1=%h, required FFFF/0000", served_cnt[0], served_cnt[1]);
    end
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    checks++;
    if (served_cnt[0] !== 16'h0) begin
      errors++;
      $display("FAIL stats_clr: cnt0=%h, required 0000", served_cnt[0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_early_empty();
    test_backpressure();
    test_clr_mid();
    test_random();
`ifdef FIFO_WRR_SCHEDULER_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
